// File: rtl/cpu_mmu_pt_seq.sv
// MMU page-table access sequencer: phases RAM strobes for translate, map write and
// cache-inhibit write, latches PT/PPN/CINH and performs the permit/ring check.
module cpu_mmu_pt_seq (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ,
  input  logic [1:0]  CMD,
  input  logic [1:0]  ACC,
  input  logic [1:0]  RING_CUR,
  input  logic [10:0] LA_IN,
  input  logic [15:0] WD_PT,
  input  logic [15:0] WD_PPN,
  output logic [10:0] LA_20_10,
  output logic        EPT_n,
  output logic        EPMAP_n,
  output logic        WMAP_n,
  output logic        WCLIM_n,
  output logic        PT_OE,
  output logic        PPN_OE,
  output logic [15:0] PT_WD,
  output logic [15:0] PPN_WD,
  input  logic [15:0] PT_15_0,
  input  logic [15:0] PPN_25_10_io,
  input  logic        WCINH_n,
  output logic        BUSY,
  output logic        ACK,
  output logic [15:0] PPN_Q,
  output logic [15:0] PT_Q,
  output logic        CINH,
  output logic        FAULT,
  output logic [1:0]  FCODE
);

  localparam int unsigned DataW = 16;
  localparam logic [1:0] CmdMap  = 2'b01;
  localparam logic [1:0] CmdCinh = 2'b10;
  localparam logic [1:0] AccWr   = 2'b01;
  localparam logic [1:0] AccFe   = 2'b10;

  typedef enum logic [3:0] {
    IDLE, RD1, RD2, CHK, WS, WP, WH, WS2, WP2, WH2, ACKS
  } stateT;

  stateT             state, stateNxt;
  logic [1:0]        cmdQ, accQ, ringQ, cmdEff;
  logic              accept;
  logic              faultC, needUpdC;
  logic [1:0]        fcodeC;
  logic [DataW-1:0]  updWdC;
  logic              eptNC, epmapNC, wmapNC, wclimNC, ptOeC, ppnOeC;

  // State register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= stateNxt;
  end

  // Next state, permit check, and strobe decode of the state being entered
  always_comb begin
    stateNxt = state;
    accept   = 1'b0;
    cmdEff   = (state == IDLE) ? CMD : cmdQ;
    faultC   = 1'b0;
    fcodeC   = 2'd0;
    needUpdC = ~PT_Q[11] | ((accQ == AccWr) & ~PT_Q[12]);
    updWdC   = PT_Q | DataW'(16'h0800) | ((accQ == AccWr) ? DataW'(16'h1000) : DataW'(0));
    eptNC    = 1'b1;
    epmapNC  = 1'b1;
    wmapNC   = 1'b1;
    wclimNC  = 1'b1;
    ptOeC    = 1'b0;
    ppnOeC   = 1'b0;

    if (PT_Q[15:13] == 3'b000) begin
      faultC = 1'b1; fcodeC = 2'd3;
    end else if (ringQ < PT_Q[10:9]) begin
      faultC = 1'b1; fcodeC = 2'd2;
    end else if ((accQ == AccWr && !PT_Q[15]) || (accQ == AccFe && !PT_Q[13]) ||
                 ((accQ == 2'b00 || accQ == 2'b11) && !PT_Q[14])) begin
      faultC = 1'b1; fcodeC = 2'd1;
    end

    case (state)
      IDLE: if (REQ) begin
        accept   = 1'b1;
        stateNxt = (CMD == CmdMap || CMD == CmdCinh) ? WS : RD1;
      end
      RD1:  stateNxt = RD2;
      RD2:  stateNxt = CHK;
      CHK:  stateNxt = (!faultC && needUpdC) ? WS : ACKS;
      WS:   stateNxt = WP;
      WP:   stateNxt = WH;
      WH:   stateNxt = (cmdQ == CmdMap) ? WS2 : ACKS;
      WS2:  stateNxt = WP2;
      WP2:  stateNxt = WH2;
      WH2:  stateNxt = ACKS;
      ACKS: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase

    case (stateNxt)
      RD1, RD2: begin
        eptNC   = 1'b0;
        epmapNC = 1'b0;
      end
      WS, WP, WH: begin
        if (cmdEff == CmdCinh) begin
          ppnOeC  = 1'b1;
          wclimNC = (stateNxt != WP);
        end else begin
          eptNC   = 1'b0;
          ptOeC   = 1'b1;
          wmapNC  = (stateNxt != WP);
        end
      end
      WS2, WP2, WH2: begin
        epmapNC = 1'b0;
        ppnOeC  = 1'b1;
        wmapNC  = (stateNxt != WP2);
      end
      default: ;
    endcase
  end

  // Registered outputs, request capture and read-data latching
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      EPT_n    <= 1'b1;
      EPMAP_n  <= 1'b1;
      WMAP_n   <= 1'b1;
      WCLIM_n  <= 1'b1;
      PT_OE    <= 1'b0;
      PPN_OE   <= 1'b0;
      BUSY     <= 1'b0;
      ACK      <= 1'b0;
      FAULT    <= 1'b0;
      FCODE    <= 2'd0;
      CINH     <= 1'b0;
      PT_Q     <= '0;
      PPN_Q    <= '0;
      PT_WD    <= '0;
      PPN_WD   <= '0;
      LA_20_10 <= '0;
      cmdQ     <= 2'd0;
      accQ     <= 2'd0;
      ringQ    <= 2'd0;
    end else begin
      EPT_n   <= eptNC;
      EPMAP_n <= epmapNC;
      WMAP_n  <= wmapNC;
      WCLIM_n <= wclimNC;
      PT_OE   <= ptOeC;
      PPN_OE  <= ppnOeC;
      BUSY    <= (stateNxt != IDLE);
      ACK     <= (stateNxt == ACKS);
      if (accept) begin
        cmdQ     <= CMD;
        accQ     <= ACC;
        ringQ    <= RING_CUR;
        LA_20_10 <= LA_IN;
        FAULT    <= 1'b0;
        FCODE    <= 2'd0;
        if (CMD == CmdMap) PT_WD <= WD_PT;
        if (CMD == CmdMap || CMD == CmdCinh) PPN_WD <= WD_PPN;
      end
      if (state == RD2) begin
        PT_Q  <= PT_15_0;
        PPN_Q <= PPN_25_10_io;
        CINH  <= ~WCINH_n;
      end
      if (state == CHK) begin
        FAULT <= faultC;
        FCODE <= fcodeC;
        if (!faultC && needUpdC) PT_WD <= updWdC;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mmu_pt_seq.sv
// Directed bench for cpu_mmu_pt_seq with a behavioural PT/PPN/CINH RAM bank model.
module tb_cpu_mmu_pt_seq;

  logic        CLK, RESET_n, REQ;
  logic [1:0]  CMD, ACC, RING_CUR;
  logic [10:0] LA_IN, LA_20_10;
  logic [15:0] WD_PT, WD_PPN, PT_WD, PPN_WD, PT_15_0, PPN_25_10_io, PPN_Q, PT_Q;
  logic        EPT_n, EPMAP_n, WMAP_n, WCLIM_n, PT_OE, PPN_OE, WCINH_n;
  logic        BUSY, ACK, CINH, FAULT;
  logic [1:0]  FCODE;

  logic [15:0] ptMem  [0:2047];
  logic [15:0] ppnMem [0:2047];
  logic        cinhMem[0:16383];

  int nAssert = 0, nFail = 0, oeViol = 0;
  int ackCyc, wmapCnt, wmapCyc, wclimCnt, wclimCyc, ptPulseCyc, ppnPulseCyc;
  logic [15:0] wmapPtWd;
  logic fltQ, postBusy;
  logic [1:0] fcQ;

  cpu_mmu_pt_seq dut (
    .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .CMD(CMD), .ACC(ACC),
    .RING_CUR(RING_CUR), .LA_IN(LA_IN), .WD_PT(WD_PT), .WD_PPN(WD_PPN),
    .LA_20_10(LA_20_10), .EPT_n(EPT_n), .EPMAP_n(EPMAP_n), .WMAP_n(WMAP_n),
    .WCLIM_n(WCLIM_n), .PT_OE(PT_OE), .PPN_OE(PPN_OE), .PT_WD(PT_WD),
    .PPN_WD(PPN_WD), .PT_15_0(PT_15_0), .PPN_25_10_io(PPN_25_10_io),
    .WCINH_n(WCINH_n), .BUSY(BUSY), .ACK(ACK), .PPN_Q(PPN_Q), .PT_Q(PT_Q),
    .CINH(CINH), .FAULT(FAULT), .FCODE(FCODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM bank: combinational reads, writes mid-pulse
  assign PT_15_0      = ptMem[LA_20_10];
  assign PPN_25_10_io = ppnMem[LA_20_10];
  assign WCINH_n      = ~cinhMem[PPN_25_10_io[13:0]];

  always @(negedge CLK) begin
    if (!WMAP_n && !EPT_n && PT_OE)    ptMem[LA_20_10]  <= PT_WD;
    if (!WMAP_n && !EPMAP_n && PPN_OE) ppnMem[LA_20_10] <= PPN_WD;
    if (!WCLIM_n && PPN_OE)            cinhMem[PPN_WD[13:0]] <= PPN_WD[15];
    if (PT_OE && PPN_OE) oeViol <= oeViol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled after acceptance, optional REQ injected while busy
  task automatic run(input logic [1:0] cmd, input logic [1:0] acc, input logic [1:0] ring,
                     input logic [10:0] la, input logic [15:0] wpt, input logic [15:0] wppn,
                     input bit injectReq);
    ackCyc = 0; wmapCnt = 0; wmapCyc = 0; wclimCnt = 0; wclimCyc = 0;
    ptPulseCyc = 0; ppnPulseCyc = 0; wmapPtWd = '0; fltQ = 1'bx; fcQ = 2'bxx;
    @(negedge CLK);
    CMD = cmd; ACC = acc; RING_CUR = ring; LA_IN = la; WD_PT = wpt; WD_PPN = wppn; REQ = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        REQ = 1'b0; CMD = ~cmd; ACC = ~acc; RING_CUR = ~ring; LA_IN = ~la;
        WD_PT = ~wpt; WD_PPN = ~wppn;
      end
      if (injectReq && k == 2) REQ = 1'b1;
      if (k == 3) REQ = 1'b0;
      if (!WMAP_n) begin
        wmapCnt++; wmapCyc = k; wmapPtWd = PT_WD;
        if (PT_OE)  ptPulseCyc = k;
        if (PPN_OE) ppnPulseCyc = k;
      end
      if (!WCLIM_n) begin wclimCnt++; wclimCyc = k; end
      if (ACK) begin
        ackCyc = k; fltQ = FAULT; fcQ = FCODE;
        break;
      end
    end
    REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    postBusy = BUSY;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin ptMem[i] = '0; ppnMem[i] = '0; end
    for (int i = 0; i < 16384; i++) cinhMem[i] = 1'b0;
    ptMem[11'h123] = 16'hC800; ppnMem[11'h123] = 16'h1234;
    ptMem[11'h010] = 16'hC000; ppnMem[11'h010] = 16'h0042;
    ptMem[11'h021] = 16'h4400;
    ptMem[11'h022] = 16'h4800;
    ptMem[11'h050] = 16'h4800; ppnMem[11'h050] = 16'h0005;
    REQ = 1'b0; CMD = '0; ACC = '0; RING_CUR = '0; LA_IN = '0; WD_PT = '0; WD_PPN = '0;
    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ept_n", 32'(EPT_n), 32'd1);
    chk("rst_wmap_n", 32'(WMAP_n), 32'd1);
    chk("rst_oe", 32'({PT_OE, PPN_OE}), 32'd0);
    chk("rst_busy_ack", 32'({BUSY, ACK, FAULT, CINH}), 32'd0);
    chk("rst_ptq_la", 32'({PT_Q, LA_20_10}), 32'd0);
    RESET_n = 1'b1;

    // Translate read, no update; REQ while busy must be dropped
    run(2'b00, 2'b00, 2'd0, 11'h123, 16'h0, 16'h0, 1'b1);
    chk("rd_ack_cyc", 32'(ackCyc), 32'd4);
    chk("rd_fault", 32'(fltQ), 32'd0);
    chk("rd_wmap_cnt", 32'(wmapCnt), 32'd0);
    chk("rd_ppnq", 32'(PPN_Q), 32'h1234);
    chk("rd_ptq", 32'(PT_Q), 32'hC800);
    chk("rd_cinh", 32'(CINH), 32'd0);
    chk("rd_req_dropped", 32'(postBusy), 32'd0);

    // Translate write with PGU/WIP update
    run(2'b00, 2'b01, 2'd0, 11'h010, 16'h0, 16'h0, 1'b0);
    chk("wr_ack_cyc", 32'(ackCyc), 32'd7);
    chk("wr_wmap_cnt", 32'(wmapCnt), 32'd1);
    chk("wr_wmap_cyc", 32'(wmapCyc), 32'd5);
    chk("wr_pt_wd", 32'(wmapPtWd), 32'hD800);
    chk("wr_ptq_pre", 32'(PT_Q), 32'hC000);
    chk("wr_mem", 32'(ptMem[11'h010]), 32'hD800);

    // Faults in priority order
    run(2'b00, 2'b00, 2'd0, 11'h020, 16'h0, 16'h0, 1'b0);
    chk("pf_code", 32'({fltQ, fcQ}), 32'({1'b1, 2'd3}));
    chk("pf_ack_wmap", 32'({ackCyc[7:0], wmapCnt[7:0]}), 32'({8'd4, 8'd0}));
    run(2'b00, 2'b00, 2'd1, 11'h021, 16'h0, 16'h0, 1'b0);
    chk("ring_code", 32'({fltQ, fcQ}), 32'({1'b1, 2'd2}));
    chk("ring_wmap", 32'(wmapCnt), 32'd0);
    run(2'b00, 2'b10, 2'd3, 11'h022, 16'h0, 16'h0, 1'b0);
    chk("perm_code", 32'({fltQ, fcQ}), 32'({1'b1, 2'd1}));
    chk("perm_wmap", 32'(wmapCnt), 32'd0);

    // Map write, then read back
    run(2'b01, 2'b00, 2'd0, 11'h7FF, 16'hE000, 16'h0ABC, 1'b0);
    chk("map_ack_cyc", 32'(ackCyc), 32'd7);
    chk("map_wmap_cnt", 32'(wmapCnt), 32'd2);
    chk("map_pt_pulse", 32'(ptPulseCyc), 32'd2);
    chk("map_ppn_pulse", 32'(ppnPulseCyc), 32'd5);
    chk("map_fault", 32'(fltQ), 32'd0);
    chk("map_wclim", 32'(wclimCnt), 32'd0);
    run(2'b11, 2'b00, 2'd0, 11'h7FF, 16'h0, 16'h0, 1'b0);
    chk("mapchk_ptq", 32'(PT_Q), 32'hE000);
    chk("mapchk_ppnq", 32'(PPN_Q), 32'h0ABC);
    chk("mapchk_fault", 32'(fltQ), 32'd0);

    // Cache-inhibit write, then translate hitting that PPN
    run(2'b10, 2'b00, 2'd0, 11'h000, 16'h0, 16'h8005, 1'b0);
    chk("ci_ack_cyc", 32'(ackCyc), 32'd4);
    chk("ci_wclim", 32'({wclimCnt[7:0], wclimCyc[7:0]}), 32'({8'd1, 8'd2}));
    chk("ci_wmap", 32'(wmapCnt), 32'd0);
    run(2'b00, 2'b00, 2'd0, 11'h050, 16'h0, 16'h0, 1'b0);
    chk("ci_cinh", 32'(CINH), 32'd1);
    chk("ci_rd_ack", 32'(ackCyc), 32'd4);
    chk("oe_exclusive", 32'(oeViol), 32'd0);

    // Reset asserted during WP of a map write
    @(negedge CLK);
    CMD = 2'b01; LA_IN = 11'h300; WD_PT = 16'hFFFF; WD_PPN = 16'h1111; REQ = 1'b1;
    @(posedge CLK);
    @(negedge CLK); REQ = 1'b0;
    @(negedge CLK);
    chk("abort_pre_wmap", 32'(WMAP_n), 32'd0);
    #2 RESET_n = 1'b0;
    #1;
    chk("abort_wmap_n", 32'(WMAP_n), 32'd1);
    chk("abort_oe_busy", 32'({PT_OE, PPN_OE, BUSY, ACK}), 32'd0);
    chk("abort_ept_n", 32'(EPT_n), 32'd1);
    @(negedge CLK); RESET_n = 1'b1;
    run(2'b00, 2'b00, 2'd0, 11'h123, 16'h0, 16'h0, 1'b0);
    chk("post_rst_ack", 32'(ackCyc), 32'd4);
    chk("post_rst_ppnq", 32'(PPN_Q), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/cpu_mmu_pt_seq.md
# cpu_mmu_pt_seq

MMU page-table access sequencer that sits directly upstream of the page-table/PPN/cache-inhibit RAM bank. It turns CPU translation requests and map-maintenance commands into properly phased RAM strobes (EPT_n, EPMAP_n, WMAP_n, WCLIM_n), latches the returned PT word, PPN and WCINH_n, and performs the permit/ring check. It also writes back the page-used (PGU) and written-in-page (WIP) bits when they need setting.

## Interface
Parameters: none. Widths are fixed by the RAM bank.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- REQ  in  1  one-cycle request pulse; accepted only while BUSY=0.
- CMD  in  2  00 translate, 01 map write (PT+PPN), 10 cache-inhibit write, 11 reserved (treated as translate).
- ACC  in  2  translate access kind: 00 read, 01 write, 10 fetch.
- RING_CUR  in  2  current ring of the requester.
- LA_IN  in  11  logical page (LA 20:10).
- WD_PT  in  16  PT data for map write.
- WD_PPN  in  16  PPN data for map or cache-inhibit write; bit 15 is the CINH data bit.
- LA_20_10  out  11  RAM address (registered copy of LA_IN).
- EPT_n, EPMAP_n, WMAP_n, WCLIM_n  out  1 each  RAM strobes, registered.
- PT_OE, PPN_OE  out  1 each  enables for driving PT_WD / PPN_WD onto the bidirectional RAM buses.
- PT_WD, PPN_WD  out  16 each  write data.
- PT_15_0, PPN_25_10_io  in  16 each  RAM read data.
- WCINH_n  in  1  cache-inhibit RAM output.
- BUSY  out  1  high from the cycle after acceptance through the ACK cycle.
- ACK  out  1  one-cycle completion pulse.
- PPN_Q  out  16  latched PPN.
- PT_Q  out  16  latched PT, before update.
- CINH  out  1  latched ~WCINH_n.
- FAULT  out  1  translation refused; valid with ACK.
- FCODE  out  2  fault code; valid with ACK.

## Operation
PT word format:
- [15] WPM, [14] RPM, [13] FPM, [12] WIP, [11] PGU, [10:9] RING.
- Remaining bits are stored but ignored.

States: IDLE, RD1, RD2, CHK, WS, WP, WH, WS2, WP2, WH2, ACKS.

Translate (CMD 00/11):
- IDLE→RD1→RD2: EPT_n=EPMAP_n=0, WMAP_n=1.
- At the RD2→CHK edge, capture PT_Q, PPN_Q and CINH.
- CHK evaluates faults in this priority order:
  - FCODE=3 page fault: WPM=RPM=FPM=0.
  - FCODE=2 ring violation: RING_CUR < PT RING.
  - FCODE=1 permit violation: read needs RPM, write needs WPM, fetch needs FPM.
- CHK exits:
  - Fault → ACKS with FAULT=1. No update.
  - No fault and an update is needed (PGU=0, or ACC=write and WIP=0) → WS/WP/WH.
    - PT_WD = PT_Q | PGU | (write ? WIP : 0).
    - EPT_n=0 and EPMAP_n=1 in all three states. PT_OE=1 in all three states.
    - WMAP_n=0 only in WP.
    - Then → ACKS.
  - Otherwise → ACKS.

Map write (CMD 01):
- WS/WP/WH write WD_PT with EPT_n=0.
- WS2/WP2/WH2 write WD_PPN with EPMAP_n=0, EPT_n=1, PPN_OE=1.
- WMAP_n=0 only in the pulse states.
- Then → ACKS.
- FAULT=0.

Cache-inhibit write (CMD 10):
- WS/WP/WH with EPT_n=EPMAP_n=1 and PPN_OE=1.
- PPN_WD=WD_PPN: RAM address is bits 13:0, data is bit 15.
- WCLIM_n=0 only in WP.
- Then → ACKS.

General rules:
- ACKS lasts one cycle → IDLE.
- REQ while BUSY=1 is ignored and not queued.
- CMD, ACC, RING_CUR, LA_IN and WD_* are registered at acceptance. Later input changes have no effect.
- PT_OE and PPN_OE are never both high.
- An output enable is never high while EPT_n/EPMAP_n select that bank for read (WMAP_n=1 with OE).

## Timing
- Acceptance edge = E0. RD1 occupies cycle 1.
- Translate without update: ACK in cycle 4.
- Translate with update: ACK in cycle 7.
- Map write: ACK in cycle 7.
- Cache-inhibit write: ACK in cycle 4.
- WMAP_n/WCLIM_n are low for exactly one cycle. Address and data are stable one cycle before and after the pulse.
- Reset values: strobes 1; OEs 0; BUSY, ACK, FAULT, CINH 0; FCODE 0; PT_Q, PPN_Q, PT_WD, PPN_WD, LA_20_10 all 0; state IDLE.
- Reset asserted mid-operation: strobes deassert and OEs drop immediately (asynchronous), with no ACK. The first REQ after release is accepted normally.
- REQ in the ACKS cycle is ignored. REQ in the first IDLE cycle after ACKS is accepted.

## Test plan
- Reset, then translate read: LA 0x123, PT=0xC800 (WPM,RPM,PGU), ring 0. Expect ACK at cycle 4, FAULT=0, no WMAP_n pulse, PPN_Q equals the RAM value.
- Translate write: PT=0xC000, RING_CUR=0. Expect a WMAP_n pulse in cycle 5 with PT_WD=0xD800, ACK at cycle 7.
- Faults:
  - PT=0x0000 → FCODE=3.
  - PT=0x4400 (ring 2), RING_CUR=1 → FCODE=2.
  - PT=0x4800, ACC=fetch → FCODE=1.
  - All three: no write strobe.
- Map write: LA 0x7FF, WD_PT=0xE000, WD_PPN=0x0ABC. Expect PT write then PPN write. OEs are exclusive. ACK at cycle 7. A read-back translate returns 0xE000/0x0ABC.
- Cache-inhibit write: WD_PPN=0x8005. Expect a single WCLIM_n pulse in cycle 2. A later translate with PPN 0x0005 gives CINH=1.
- Reset asserted during WP: WMAP_n and PT_OE inactive immediately, BUSY=0. A REQ pulse while BUSY=1 is dropped.
